// File: rtl/mdseq_pkg.sv
// Shared definitions for the sequential multiply/divide controller.
// State and op encodings plus the iteration count of the datapath.
package mdseq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_WRITE = 3'd3,
    S_EXC   = 3'd4
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = $clog2(ITER_COUNT);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITER_COUNT - 1);

endpackage

// File: rtl/mult_div_seq.sv
// Control FSM sequencing a 32-step multiply/divide datapath.
// Define MDSEQ_DIVZERO_EN to trap divide-by-zero in an EXC state.
module mult_div_seq
  import mdseq_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] operand_b,
  output logic        load,
  output logic        mult_step,
  output logic        div_step,
  output logic        hi_write,
  output logic        lo_write,
  output logic        mux_hi,
  output logic        mux_lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             op_q;
  logic             accept;
  logic             trap;

  assign accept = (state_q == S_IDLE) && start;

`ifdef MDSEQ_DIVZERO_EN
  assign trap = (op == OP_DIV) && (operand_b == '0);
`else
  logic unused_b;
  assign unused_b = ^operand_b;
  assign trap     = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_INIT;
      op_q    <= OP_MULT;
    end else begin
      state_q <= state_d;
      if (accept)
        op_q <= op;
      if (state_q == S_LOAD)
        cnt_q <= CNT_INIT;
      else if (state_q == S_RUN)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  // mux selects simply follow op_q, which only moves on an accepted start
  assign mux_hi = op_q;
  assign mux_lo = op_q;
  assign busy   = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    mult_step = 1'b0;
    div_step  = 1'b0;
    hi_write  = 1'b0;
    lo_write  = 1'b0;
    done      = 1'b0;
    div_zero  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start)
          state_d = trap ? S_EXC : S_LOAD;
      end
      S_LOAD: begin
        load    = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        mult_step = (op_q == OP_MULT);
        div_step  = (op_q == OP_DIV);
        if (cnt_q == '0)
          state_d = S_WRITE;
      end
      S_WRITE: begin
        hi_write = 1'b1;
        lo_write = 1'b1;
        done     = 1'b1;
        state_d  = S_IDLE;
      end
`ifdef MDSEQ_DIVZERO_EN
      S_EXC: begin
        div_zero = 1'b1;
        state_d  = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/mult_div_seq.md
MULT_DIV_SEQ -- requirements
Module: mult_div_seq

Interface
REQ-001 clock  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 start  in  1  request to begin an operation; sampled only in IDLE.
REQ-004 op  in  1  operation select: 0 = MULT, 1 = DIV; captured with start.
REQ-005 operand_b  in  32  divisor/multiplier value, used for divide-by-zero detection only.
REQ-006 load  out  1  one-cycle pulse that loads operands into the mult/div datapath.
REQ-007 mult_step  out  1  per-iteration enable to the multiplier.
REQ-008 div_step  out  1  per-iteration enable to the divider.
REQ-009 hi_write  out  1  write enable for the HI register.
REQ-010 lo_write  out  1  write enable for the LO register.
REQ-011 mux_hi  out  1  HI source select: 0 = multiplier, 1 = divider.
REQ-012 mux_lo  out  1  LO source select: 0 = multiplier, 1 = divider.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 div_zero  out  1  one-cycle divide-by-zero exception pulse.

Function
REQ-016 States: IDLE, LOAD, RUN, WRITE, EXC; encoding 3 bits.
REQ-017 IDLE: start=1 -> latch op into op_q and go to LOAD; start=0 -> stay in IDLE.
REQ-018 LOAD: load=1 for exactly one cycle; iteration counter set to 31; next state RUN.
REQ-019 RUN: mult_step=op_q==0, div_step=op_q==1 every cycle; counter decrements by 1 per cycle.
REQ-020 RUN: counter==0 -> next state WRITE; RUN lasts exactly 32 cycles.
REQ-021 WRITE: hi_write=lo_write=1, mux_hi=mux_lo=op_q, done=1 for one cycle; next state IDLE.
REQ-022 Latency: start in cycle N -> load in N+1, steps in N+2..N+33, hi/lo write and done in N+34.
REQ-023 start while busy is ignored; no queuing, and op_q does not change.
REQ-024 Counter is 5-bit unsigned; it does not wrap below 0 because RUN exits at 0.
REQ-025 mux_hi and mux_lo hold op_q from LOAD until the next accepted start.
REQ-026 hi_write, lo_write, load, done and div_zero are never high outside their defined states.
REQ-027 A new start is accepted in the cycle after WRITE or EXC, giving back-to-back operations.

Reset
REQ-028 Reset forces IDLE, counter=31, op_q=0, and all outputs 0, including busy.
REQ-029 Reset mid-operation (LOAD, RUN, WRITE) aborts the operation with no hi_write/lo_write and no done.
REQ-030 Reset has priority over start in the same cycle.

Configuration
REQ-031 Macro MDSEQ_DIVZERO_EN defined: in IDLE, start=1 with op=1 and operand_b==0 goes to EXC.
REQ-032 EXC: div_zero=1 and busy=1 for one cycle; no load, steps or hi/lo write; next state IDLE.
REQ-033 Macro MDSEQ_DIVZERO_EN undefined: EXC and div_zero logic are absent; div_zero is tied 0; divide by zero runs the normal 32-step sequence.

Structure
REQ-034 Shared package mdseq_pkg holds the state encoding, the op encoding (OP_MULT=0, OP_DIV=1) and the constant ITER_COUNT=32.
REQ-035 The block is a single module with no sub-module; the counter and FSM are inline.

Verification
REQ-036 MULT, start=1 op=0 at cycle 0 -> load at 1; mult_step at 2..33; hi_write, lo_write and done at 34; mux_hi=mux_lo=0.
REQ-037 DIV, operand_b=7 -> same timing with div_step; mux_hi=mux_lo=1 at 34.
REQ-038 DIV, operand_b=0 with macro defined -> div_zero at cycle 1; no load or hi_write; busy low at 2. With macro undefined -> normal 34-cycle sequence.
REQ-039 start pulsed at cycle 10 during a MULT -> ignored; a single done at 34; op_q unchanged.
REQ-040 reset asserted at cycle 20 of a DIV -> IDLE at 21; no hi_write or done; a new start at 22 completes at 56.
REQ-041 Back-to-back: start held high continuously -> done at 34, second load at 36, second done at 69.
